// File: rtl/rv32_instr_prefetch.sv
// RV32 instruction prefetch buffer: a credit-limited request stream into a
// small FIFO, delivering in-order words to the core with redirect/discard.
module rv32_instr_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_req_i,
    input  logic [31:0] fetch_addr_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fifo_q [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [31:2]   pf_addr;
    logic [31:2]   dl_addr;

    logic          match;
    logic          redirect;
    logic          fifo_empty;
    logic [CW:0]   credit_used;
    logic          grant;
    logic          rsp;
    logic          push;
    logic          pop;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^fetch_addr_i[1:0];

    // Handshake decode, credit check and head-of-FIFO delivery
    always_comb begin
        match         = fetch_addr_i[31:2] == dl_addr;
        redirect      = fetch_req_i && !match;
        fifo_empty    = count == '0;
        credit_used   = {1'b0, count} + {1'b0, outstanding};
        mem_req_o     = !rst_i && !redirect && (credit_used < DEPTH_W);
        mem_addr_o    = {pf_addr, 2'b00};
        instr_valid_o = !rst_i && fetch_req_i && match && !fifo_empty;
        instr_o       = fifo_empty ? 32'h0 : fifo_q[rd_ptr];
        grant         = mem_req_o && mem_gnt_i;
        rsp           = mem_rvalid_i && (outstanding != '0);
        push          = rsp && !redirect && (discard == '0);
        pop           = instr_valid_o;
    end

    // Address, pointer and counter state; a redirect flushes everything
    // and turns every in-flight response into one to be dropped
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pf_addr     <= RESET_PC[31:2];
            dl_addr     <= RESET_PC[31:2];
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect) begin
            pf_addr     <= fetch_addr_i[31:2];
            dl_addr     <= fetch_addr_i[31:2];
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= outstanding - CW'(rsp);
            discard     <= outstanding - CW'(rsp);
        end else begin
            if (grant) begin
                pf_addr <= pf_addr + 30'd1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                dl_addr <= dl_addr + 30'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            count       <= count + CW'(push) - CW'(pop);
            outstanding <= outstanding + CW'(grant) - CW'(rsp);
            if (rsp && discard != '0) begin
                discard <= discard - 1'b1;
            end
        end
    end

    // FIFO storage; no reset needed since count guards every read
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr] <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_rv32_instr_prefetch.sv
// Bench for rv32_instr_prefetch: queue-based reference model of the
// prefetcher plus a randomised in-order memory returning addr^A5A5_0000.
module tb_rv32_instr_prefetch;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    rv32_instr_prefetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .fetch_req_i   (fetch_req),
        .fetch_addr_i  (fetch_addr),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt),
        .mem_rvalid_i  (mem_rvalid),
        .mem_rdata_i   (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int gnt_pct = 100;
    int rv_pct = 100;

    // memory side: pending response data, oldest first
    logic [31:0] rsp_q[$];

    // reference model: next request / next delivery address, buffered
    // words, and one drop flag per request still in flight
    logic [31:0] m_pf;
    logic [31:0] m_dl;
    logic [31:0] m_fifo[$];
    bit          m_drop[$];

    logic        obs_valid;
    logic        obs_req;
    logic [31:0] obs_instr;
    logic [31:0] obs_addr;
    int          n_gnt;
    int          n_vld;
    logic [31:0] first_instr;
    bit          got_first;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // one clock cycle: drive, check against model, advance model and memory
    task automatic tick(input bit f_req, input logic [31:0] f_addr);
        bit          match;
        bit          redir;
        bit          e_req;
        bit          e_vld;
        bit          g;
        bit          rsp;
        bit          drop;
        logic [31:0] e_instr;
        logic [31:0] g_addr;
        fetch_req  = f_req;
        fetch_addr = f_addr;
        mem_gnt    = ($urandom_range(99) < 32'(gnt_pct));
        mem_rvalid = (rsp_q.size() > 0) && ($urandom_range(99) < 32'(rv_pct));
        mem_rdata  = (rsp_q.size() > 0) ? rsp_q[0] : $urandom;
        #1;
        match   = (f_addr[31:2] == m_dl[31:2]);
        redir   = f_req && !match;
        e_req   = !redir && (m_fifo.size() + m_drop.size() < DEPTH);
        e_vld   = f_req && match && (m_fifo.size() > 0);
        e_instr = (m_fifo.size() > 0) ? m_fifo[0] : 32'h0;
        obs_valid = instr_valid_o;
        obs_req   = mem_req_o;
        obs_instr = instr_o;
        obs_addr  = mem_addr_o;
        chk1("mem_req", mem_req_o, e_req);
        if (e_req) chk("mem_addr", mem_addr_o, m_pf);
        chk1("instr_valid", instr_valid_o, e_vld);
        chk("instr", instr_o, e_instr);
        if (e_vld) chk("instr_word", instr_o, m_dl ^ KEY);
        g      = mem_req_o && mem_gnt;
        g_addr = mem_addr_o;
        rsp    = mem_rvalid && (m_drop.size() > 0);
        if (instr_valid_o) begin
            n_vld++;
            if (!got_first) begin
                got_first   = 1'b1;
                first_instr = instr_o;
            end
        end
        if (g) n_gnt++;
        @(posedge clk);
        drop = 1'b1;
        if (rsp) drop = m_drop.pop_front();
        if (redir) begin
            m_fifo.delete();
            foreach (m_drop[i]) m_drop[i] = 1'b1;
            m_pf = {f_addr[31:2], 2'b00};
            m_dl = m_pf;
        end else begin
            if (e_vld) begin
                void'(m_fifo.pop_front());
                m_dl += 32'd4;
            end
            if (rsp && !drop) m_fifo.push_back(mem_rdata);
            if (e_req && mem_gnt) begin
                m_drop.push_back(1'b0);
                m_pf += 32'd4;
            end
        end
        if (mem_rvalid) void'(rsp_q.pop_front());
        if (g) rsp_q.push_back(g_addr ^ KEY);
        @(negedge clk);
    endtask

    // asynchronous reset pulse mid-cycle; optionally keep stale responses
    task automatic do_reset(input bit keep_q);
        fetch_req  = 1'b1;
        fetch_addr = RST_PC;
        #2 rst = 1'b1;
        #1;
        chk1("rst_mem_req", mem_req_o, 1'b0);
        chk1("rst_valid", instr_valid_o, 1'b0);
        chk("rst_instr", instr_o, 32'h0);
        m_pf = RST_PC;
        m_dl = RST_PC;
        m_fifo.delete();
        m_drop.delete();
        if (keep_q) begin
            foreach (rsp_q[i]) rsp_q[i] = 32'hDEAD_BEEF;
        end else begin
            rsp_q.delete();
        end
        fetch_req  = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int r;
        rst        = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        @(negedge clk);
        do_reset(1'b0);

        // idle core: credit allows exactly DEPTH requests
        gnt_pct = 100;
        rv_pct  = 100;
        n_gnt   = 0;
        repeat (10) tick(1'b0, m_dl);
        chk("idle_grants", 32'(n_gnt), 32'd4);
        chk1("idle_req_low", obs_req, 1'b0);

        // resume: buffered words back to back, then steady streaming
        n_vld     = 0;
        got_first = 1'b0;
        repeat (4) tick(1'b1, m_dl);
        chk("b2b_words", 32'(n_vld), 32'd4);
        chk("first_word", first_instr, 32'hA5A5_0000);
        n_vld = 0;
        repeat (20) tick(1'b1, m_dl);
        chk("stream_words", 32'(n_vld), 32'd20);

        // redirect with nothing outstanding: word at T+3
        repeat (10) tick(1'b0, m_dl);
        tick(1'b1, 32'h0000_0100);
        chk1("t0_req", obs_req, 1'b0);
        chk1("t0_valid", obs_valid, 1'b0);
        tick(1'b1, 32'h0000_0100);
        chk1("t1_valid", obs_valid, 1'b0);
        chk("t1_addr", obs_addr, 32'h0000_0100);
        tick(1'b1, 32'h0000_0100);
        chk1("t2_valid", obs_valid, 1'b0);
        tick(1'b1, 32'h0000_0100);
        chk1("t3_valid", obs_valid, 1'b1);
        chk("t3_instr", obs_instr, 32'hA5A5_0100);

        // reset with 3 outstanding, stray responses, grant withheld
        do_reset(1'b0);
        rv_pct = 0;
        repeat (3) tick(1'b0, m_dl);
        do_reset(1'b1);
        gnt_pct = 0;
        rv_pct  = 100;
        n_vld   = 0;
        repeat (5) begin
            tick(1'b1, m_dl);
            chk1("hold_req", obs_req, 1'b1);
            chk("hold_addr", obs_addr, RST_PC);
        end
        chk("hold_valid", 32'(n_vld), 32'd0);
        gnt_pct   = 100;
        got_first = 1'b0;
        repeat (6) tick(1'b1, m_dl);
        chk("post_rst_first", first_instr, RST_PC ^ KEY);

        // redirect with 2 outstanding: both stale words dropped
        do_reset(1'b0);
        rv_pct = 0;
        repeat (2) tick(1'b0, m_dl);
        got_first = 1'b0;
        tick(1'b1, 32'h0000_0100);
        chk1("rd2_req", obs_req, 1'b0);
        rv_pct = 100;
        tick(1'b1, 32'h0000_0100);
        chk1("rd2_req_next", obs_req, 1'b1);
        chk("rd2_addr_next", obs_addr, 32'h0000_0100);
        repeat (6) tick(1'b1, m_dl);
        chk("rd2_first", first_instr, 32'hA5A5_0100);

        // redirect coinciding with a response
        do_reset(1'b0);
        rv_pct = 0;
        repeat (2) tick(1'b0, m_dl);
        rv_pct    = 100;
        got_first = 1'b0;
        tick(1'b1, 32'h0000_0200);
        repeat (7) tick(1'b1, m_dl);
        chk("coinc_first", first_instr, 32'hA5A5_0200);

        // address wrap at the top of memory
        tick(1'b1, 32'hFFFF_FFF8);
        repeat (10) tick(1'b1, m_dl);

        // random traffic
        repeat (400) begin
            if ($urandom_range(49) == 0) begin
                gnt_pct = int'($urandom_range(100, 20));
                rv_pct  = int'($urandom_range(100, 20));
            end
            r = int'($urandom_range(99));
            if (r < 20) begin
                tick(1'b0, $urandom);
            end else if (r < 26) begin
                tick(1'b1, (32'($urandom_range(63)) << 2) | 32'($urandom_range(3)));
            end else begin
                tick(1'b1, m_dl | 32'($urandom_range(3)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv32_instr_prefetch.md
RV32_INSTR_PREFETCH -- requirements
Module: rv32_instr_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries and the maximum of FIFO occupancy plus outstanding requests (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first prefetch address after reset.
REQ-003 SHALL have port clk_i, input, 1, meaning the single clock; all state on rising edge.
REQ-004 SHALL have port rst_i, input, 1, meaning reset; reset is asynchronous and active-high.
REQ-005 SHALL have port fetch_req_i, input, 1, meaning the core requests the instruction at fetch_addr_i this cycle.
REQ-006 SHALL have port fetch_addr_i, input, 32, meaning the core fetch PC; bits [1:0] ignored.
REQ-007 SHALL have port instr_o, input-side result, output, 32, meaning the FIFO head instruction, 32'h0 when FIFO empty.
REQ-008 SHALL have port instr_valid_o, output, 1, meaning instr_o is the word at fetch_addr_i and is consumed this cycle.
REQ-009 SHALL have port mem_req_o, output, 1, meaning instruction memory request valid.
REQ-010 SHALL have port mem_addr_o, output, 32, meaning request word address, bits [1:0] = 0.
REQ-011 SHALL have port mem_gnt_i, input, 1, meaning the request is accepted this cycle.
REQ-012 SHALL have port mem_rvalid_i, input, 1, meaning one in-order response on mem_rdata_i.
REQ-013 SHALL have port mem_rdata_i, input, 32, meaning response instruction word.

Function
REQ-014 SHALL keep registers pf_addr (next request address), dl_addr (address of FIFO head or next delivery), outstanding count (0..DEPTH), and discard count (0..DEPTH).
REQ-015 SHALL assert mem_req_o when FIFO count plus outstanding < DEPTH and no redirect occurs this cycle; mem_addr_o = {pf_addr[31:2],2'b00}.
REQ-016 SHALL hold mem_req_o and mem_addr_o stable until mem_gnt_i; on mem_req_o && mem_gnt_i, pf_addr += 4 (wraps 32'hFFFF_FFFC -> 0) and outstanding increments.
REQ-017 SHALL, on mem_rvalid_i, decrement outstanding, decrement discard and drop the word if discard > 0, else push mem_rdata_i into the FIFO.
REQ-018 SHALL ignore mem_rvalid_i when outstanding = 0, leaving all state unchanged.
REQ-019 SHALL define match as fetch_addr_i[31:2] == dl_addr[31:2].
REQ-020 SHALL assert instr_valid_o combinationally when fetch_req_i && match && FIFO non-empty, then pop the head and set dl_addr += 4.
REQ-021 SHALL perform a redirect when fetch_req_i && !match, whatever the FIFO state.
REQ-022 SHALL, on redirect, set instr_valid_o = 0 and mem_req_o = 0.
REQ-023 SHALL, on redirect, empty the FIFO and set pf_addr = dl_addr = fetch_addr_i & ~3.
REQ-024 SHALL, on redirect, set discard = outstanding, minus 1 if mem_rvalid_i is also high that cycle; the coincident response is dropped.
REQ-025 SHALL, when fetch_req_i && match and the FIFO is empty, keep instr_valid_o = 0 with no redirect; this is a stall.
REQ-026 SHALL, when a push and a pop occur in the same cycle, leave the count unchanged and keep data in order.
REQ-027 SHALL never push into a full FIFO, guaranteed by the REQ-015 credit rule.
REQ-028 SHALL provide no response-to-output bypass: a pushed word is deliverable the next cycle.
REQ-029 SHALL, with a single-cycle grant and rvalid one cycle after grant, take 3 cycles from redirect (cycle T) to instr_valid_o (cycle T+3).

Reset
REQ-030 SHALL, while rst_i is high, force mem_req_o = 0, instr_valid_o = 0, instr_o = 0, an empty FIFO, outstanding = discard = 0, and pf_addr = dl_addr = RESET_PC.
REQ-031 SHALL apply REQ-030 asynchronously mid-transfer; responses after deassertion fall under REQ-018.
REQ-032 SHALL allow the first mem_req_o in the first clock edge cycle after rst_i deasserts.

Verification
REQ-033 SHALL test: reset, memory always grants, rvalid 1 cycle later returning addr^32'hA5A5_0000, fetch_req_i with sequential PCs from 0 -> instr_valid_o each cycle after warm-up, instr_o = 32'hA5A5_0000, 32'hA5A5_0004, ...
REQ-034 SHALL test: fetch_req_i low for 10 cycles -> exactly DEPTH=4 grants, mem_req_o then low; resuming fetch delivers 4 back-to-back words.
REQ-035 SHALL test: redirect to 32'h0000_0100 with 2 outstanding -> both responses dropped, next mem_addr_o = 32'h100, instr_valid_o at T+3 with word of 0x100.
REQ-036 SHALL test: redirect in the same cycle as mem_rvalid_i -> that word is not delivered, discard = outstanding-1.
REQ-037 SHALL test: mem_gnt_i withheld 5 cycles -> mem_req_o and mem_addr_o stay stable, instr_valid_o stays 0.
REQ-038 SHALL test: rst_i pulsed with 3 outstanding, then 3 stray rvalids -> ignored; the first request goes to RESET_PC.
